atm_account_store: RTL and testbench

//   Account-side responder to the ATM FSM. Holds a small bank of accounts, each with
//   a balance, a PIN and a lock bit. Per card session it:
//     - checks the PIN and drives wrong_psw;
//     - presents current_balance for the inserted card;
//     - commits the balance the FSM reports on op_done.

---
 rtl/atm_account_store.sv | 169 ++++++++++++++++
 tb/tb_atm_account_store.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_store.sv
// atm_account_store: account-side responder to the ATM FSM.
// Holds NUM_ACCOUNTS accounts. Each account has a balance, a PIN and a lock bit.
// For each card session the block checks the PIN and presents the stored
// balance. It commits the balance the FSM reports on op_done.
// Ports:
//   clk, rst               clock (rising edge), async active-low reset
//   card_in/card_id        card insertion pulse and selected account
//   pin_valid/pin          PIN entry pulse and entered PIN
//   balance/op_done/error  FSM result: new balance, done, failed
//   card_out               FSM ejects the card, which ends the session
//   cfg_we/cfg_id/cfg_pin/cfg_balance  account configuration (IDLE only)
//   wrong_psw              1 unless a verified session is open
//   current_balance        stored balance of the session account, else 0
//   pin_ok / card_locked   one-cycle pulses: PIN accepted / card rejected
//   busy                   1 whenever the block is not idle
module atm_account_store #(
  parameter int unsigned balance_width = 20,
  parameter int unsigned NUM_ACCOUNTS  = 4,
  parameter int unsigned ID_WIDTH      = 2,
  parameter int unsigned PIN_WIDTH     = 16,
  parameter int unsigned MAX_TRIES     = 3,
  parameter logic [balance_width-1:0] INIT_BALANCE = balance_width'(1000),
  parameter logic [PIN_WIDTH-1:0]     PIN_BASE     = PIN_WIDTH'(16'h1234)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic [ID_WIDTH-1:0]      card_id,
  input  logic                     pin_valid,
  input  logic [PIN_WIDTH-1:0]     pin,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_done,
  input  logic                     error,
  input  logic                     card_out,
  input  logic                     cfg_we,
  input  logic [ID_WIDTH-1:0]      cfg_id,
  input  logic [PIN_WIDTH-1:0]     cfg_pin,
  input  logic [balance_width-1:0] cfg_balance,
  output logic                     wrong_psw,
  output logic [balance_width-1:0] current_balance,
  output logic                     pin_ok,
  output logic                     card_locked,
  output logic                     busy
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_PIN, SESSION, REJECT} state_t;

  state_t                     state, state_next;
  logic [ID_WIDTH-1:0]        cur_id, id_next;
  logic [TRIES_W-1:0]         tries, tries_next;
  logic [balance_width-1:0]   bal_mem [NUM_ACCOUNTS];
  logic [PIN_WIDTH-1:0]       pin_mem [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0]    lock_mem;

  logic                       cfg_do, commit, lock_set, card_locked_eff;
  logic                       wrong_psw_next, pin_ok_next, card_locked_next, busy_next;
  logic [balance_width-1:0]   cur_bal_next;

  // Account ids at or above NUM_ACCOUNTS do not exist
  function automatic logic id_valid(input logic [ID_WIDTH-1:0] id);
    return 32'(id) < NUM_ACCOUNTS;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_next      = state;
    id_next         = cur_id;
    tries_next      = tries;
    lock_set        = 1'b0;
    pin_ok_next     = 1'b0;
    cur_bal_next    = '0;
    cfg_do          = (state == IDLE) && cfg_we && id_valid(cfg_id);
    commit          = (state == SESSION) && op_done && !error;
    // A config write in the same cycle unlocks the card before it is checked
    card_locked_eff = lock_mem[card_id] && !(cfg_do && (cfg_id == card_id));

    unique case (state)
      IDLE: begin
        if (card_in) begin
          id_next    = card_id;
          tries_next = '0;
          if (!id_valid(card_id) || card_locked_eff) state_next = REJECT;
          else                                       state_next = WAIT_PIN;
        end
      end
      WAIT_PIN: begin
        if (card_out) begin
          state_next = IDLE;
          tries_next = '0;
        end else if (pin_valid) begin
          if (pin == pin_mem[cur_id]) begin
            state_next  = SESSION;
            pin_ok_next = 1'b1;
          end else if (32'(tries) + 32'd1 >= MAX_TRIES) begin
            lock_set   = 1'b1;
            state_next = REJECT;
          end else begin
            tries_next = tries + TRIES_W'(1);
          end
        end
      end
      SESSION: begin
        if (card_out) state_next = IDLE;
      end
      REJECT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next        = (state_next != IDLE);
    wrong_psw_next   = (state_next != SESSION);
    card_locked_next = (state_next == REJECT);

    // Show balance as it will be stored after this edge, including same-cycle writes
    if ((state_next == WAIT_PIN) || (state_next == SESSION)) begin
      if (commit)                             cur_bal_next = balance;
      else if (cfg_do && (cfg_id == id_next)) cur_bal_next = cfg_balance;
      else                                    cur_bal_next = bal_mem[id_next];
    end
  end

  // State, session and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cur_id          <= '0;
      tries           <= '0;
      wrong_psw       <= 1'b1;
      current_balance <= '0;
      pin_ok          <= 1'b0;
      card_locked     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_next;
      cur_id          <= id_next;
      tries           <= tries_next;
      wrong_psw       <= wrong_psw_next;
      current_balance <= cur_bal_next;
      pin_ok          <= pin_ok_next;
      card_locked     <= card_locked_next;
      busy            <= busy_next;
    end
  end

  // Account storage: config writes, balance commits and lockout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_ACCOUNTS); i++) begin
        bal_mem[i] <= INIT_BALANCE;
        pin_mem[i] <= PIN_BASE + PIN_WIDTH'(i);
      end
      lock_mem <= '0;
    end else begin
      if (cfg_do) begin
        bal_mem[cfg_id]  <= cfg_balance;
        pin_mem[cfg_id]  <= cfg_pin;
        lock_mem[cfg_id] <= 1'b0;
      end
      if (commit)   bal_mem[cur_id]  <= balance;
      if (lock_set) lock_mem[cur_id] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_atm_account_store.sv
module tb_atm_account_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in, pin_valid, op_done, error, card_out, cfg_we;
  logic [1:0]  card_id, cfg_id;
  logic [15:0] pin, cfg_pin;
  logic [19:0] balance, cfg_balance;
  logic        wrong_psw, pin_ok, card_locked, busy;
  logic [19:0] current_balance;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_pin;
    logic [19:0] bal;
    bit          wpsw;
  } ev_t;
  ev_t evq[$];

  atm_account_store dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_id(card_id),
    .pin_valid(pin_valid), .pin(pin), .balance(balance), .op_done(op_done),
    .error(error), .card_out(card_out), .cfg_we(cfg_we), .cfg_id(cfg_id),
    .cfg_pin(cfg_pin), .cfg_balance(cfg_balance), .wrong_psw(wrong_psw),
    .current_balance(current_balance), .pin_ok(pin_ok),
    .card_locked(card_locked), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every pin_ok / card_locked pulse must match the next queued event
  always @(negedge clk) begin
    if (rst && (pin_ok || card_locked)) begin
      checks++;
      if (evq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event pin_ok=%0b card_locked=%0b required=none", pin_ok, card_locked);
      end else begin
        ev_t e;
        e = evq.pop_front();
        if (pin_ok !== e.is_pin || card_locked !== !e.is_pin ||
            current_balance !== e.bal || wrong_psw !== e.wpsw) begin
          failures++;
          $display("FAIL event got pin_ok=%0b locked=%0b bal=%0d wpsw=%0b required pin_ok=%0b locked=%0b bal=%0d wpsw=%0b",
                   pin_ok, card_locked, current_balance, wrong_psw,
                   e.is_pin, !e.is_pin, e.bal, e.wpsw);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", nm, got, exp);
    end
  endtask

  task automatic push_ev(input bit is_pin, input logic [19:0] bal, input bit wpsw);
    ev_t e;
    e.is_pin = is_pin;
    e.bal    = bal;
    e.wpsw   = wpsw;
    evq.push_back(e);
  endtask

  task automatic insert(input logic [1:0] id);
    card_id = id;
    card_in = 1'b1;
    tick();
    card_in = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    pin       = p;
    pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
  endtask

  task automatic eject();
    card_out = 1'b1;
    tick();
    card_out = 1'b0;
  endtask

  task automatic op(input logic [19:0] b, input logic err, input logic co);
    balance  = b;
    op_done  = 1'b1;
    error    = err;
    card_out = co;
    tick();
    op_done  = 1'b0;
    error    = 1'b0;
    card_out = 1'b0;
  endtask

  initial begin
    rst = 1'b0; card_in = 0; pin_valid = 0; op_done = 0; error = 0; card_out = 0;
    cfg_we = 0; card_id = 0; cfg_id = 0; pin = 0; cfg_pin = 0; balance = 0; cfg_balance = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrong_psw", 32'(wrong_psw), 1);
    chk("rst_cur_bal", 32'(current_balance), 0);
    chk("rst_pin_ok", 32'(pin_ok), 0);
    chk("rst_card_locked", 32'(card_locked), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    tick();

    // 1) correct PIN on account 1
    insert(2'd1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_wpsw_waitpin", 32'(wrong_psw), 1);
    chk("t1_bal_waitpin", 32'(current_balance), 1000);
    push_ev(1, 20'd1000, 0);
    enter_pin(16'h1235);
    chk("t1_wpsw_session", 32'(wrong_psw), 0);
    tick();
    chk("t1_pin_ok_one_cycle", 32'(pin_ok), 0);

    // 2) commit 700, eject, reinsert
    op(20'd700, 1'b0, 1'b0);
    chk("t2_bal_commit", 32'(current_balance), 700);
    eject();
    chk("t2_idle_busy", 32'(busy), 0);
    chk("t2_idle_bal", 32'(current_balance), 0);
    chk("t2_idle_wpsw", 32'(wrong_psw), 1);
    insert(2'd1);
    chk("t2_bal_persist", 32'(current_balance), 700);
    push_ev(1, 20'd700, 0);
    enter_pin(16'h1235);
    eject();

    // 3) failed operation does not commit
    insert(2'd0);
    push_ev(1, 20'd1000, 0);
    enter_pin(16'h1234);
    op(20'd5, 1'b1, 1'b0);
    chk("t3_error_no_write", 32'(current_balance), 1000);
    eject();

    // 4) lockout on account 2, reject, then unlock by config
    insert(2'd2);
    enter_pin(16'h0000);
    enter_pin(16'h0001);
    chk("t4_still_waiting", 32'(busy), 1);
    push_ev(0, 20'd0, 1);
    enter_pin(16'h0002);
    tick();
    chk("t4_back_idle", 32'(busy), 0);
    push_ev(0, 20'd0, 1);
    insert(2'd2);
    tick();
    chk("t4_reject_idle", 32'(busy), 0);
    cfg_we = 1'b1; cfg_id = 2'd2; cfg_pin = 16'hBEEF; cfg_balance = 20'd50;
    tick();
    cfg_we = 1'b0;
    insert(2'd2);
    chk("t4_cfg_bal", 32'(current_balance), 50);
    push_ev(1, 20'd50, 0);
    enter_pin(16'hBEEF);
    eject();

    // config and card insertion in the same cycle
    cfg_we = 1'b1; cfg_id = 2'd3; cfg_pin = 16'h0001; cfg_balance = 20'd77;
    card_in = 1'b1; card_id = 2'd3;
    tick();
    cfg_we = 1'b0; card_in = 1'b0;
    chk("cfg_same_cycle_bal", 32'(current_balance), 77);
    push_ev(1, 20'd77, 0);
    enter_pin(16'h0001);
    eject();

    // 5) two wrong PINs then eject: no lock, fresh tries
    insert(2'd0);
    enter_pin(16'h9999);
    enter_pin(16'h9998);
    eject();
    chk("t5_eject_idle", 32'(busy), 0);
    insert(2'd0);
    chk("t5_not_locked", 32'(busy), 1);
    enter_pin(16'h9999);
    enter_pin(16'h9998);
    chk("t5_tries_reset", 32'(busy), 1);
    // card_out wins over a correct same-cycle PIN
    pin = 16'h1234; pin_valid = 1'b1; card_out = 1'b1;
    tick();
    pin_valid = 1'b0; card_out = 1'b0;
    chk("t5_card_out_wins", 32'(busy), 0);
    insert(2'd0);
    push_ev(1, 20'd1000, 0);
    enter_pin(16'h1234);

    // 6) reset mid-session after a commit
    op(20'd700, 1'b0, 1'b0);
    chk("t6_commit", 32'(current_balance), 700);
    rst = 1'b0;
    #1;
    chk("t6_rst_wpsw", 32'(wrong_psw), 1);
    chk("t6_rst_bal", 32'(current_balance), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b1;
    tick();
    insert(2'd0);
    chk("t6_bal_restored", 32'(current_balance), 1000);
    eject();

    // commit still performed when card_out arrives with op_done
    insert(2'd1);
    chk("t7_bal_after_rst", 32'(current_balance), 1000);
    push_ev(1, 20'd1000, 0);
    enter_pin(16'h1235);
    op(20'd300, 1'b0, 1'b1);
    chk("t7_idle", 32'(busy), 0);
    insert(2'd1);
    chk("t7_commit_on_eject", 32'(current_balance), 300);
    eject();

    repeat (3) tick();
    chk("events_outstanding", 32'(evq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
